// File: rtl/fpu_sp_pkg.sv
// Shared types and constants for the single-precision floating-point adder.
// Holds the FSM state encoding and the unpacked operand format.
package fpu_sp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'd255;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;   // hidden bit in [23]
  } operand_t;

  // Denormals collapse to a signed zero, so they never reach the datapath.
  function automatic operand_t unpack(input logic [31:0] f);
    operand_t op;
    op.sign = f[31];
    op.exp  = f[30:23];
    op.sig  = (f[30:23] == 8'd0) ? 24'd0 : {1'b1, f[22:0]};
    return op;
  endfunction

endpackage

// File: rtl/fpu_sp_lzc.sv
// 27-bit leading-zero counter; an all-zero input reports 27.
module fpu_sp_lzc (
  input  logic [26:0] din,
  output logic [4:0]  cnt
);

  always_comb begin
    // NOTE: default first so every path assigns cnt and no latch is inferred.
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (din[i]) cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fpu_sp_add.sv
// Multi-cycle IEEE-754 binary32 adder: IDLE/ALIGN/ADD/NORM/ROUND/DONE,
// round-to-nearest-even, denormals flushed to zero.
module fpu_sp_add
  import fpu_sp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        dval,
  output logic [31:0] result,
  output logic        rdy
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, b_q;
  logic               sign_q, sign_s_q;
  logic signed [9:0]  exp_q;
  logic [26:0]        big_q, small_q, mant_q;
  logic [27:0]        sum_q;
  logic               zero_q, special_q;
  logic [31:0]        special_val_q, result_q;
  logic               rdy_q;

  // ALIGN: unpack, classify specials, order by magnitude, shift with sticky
  operand_t    op_a, op_b, op_big, op_small;
  logic        a_nan, b_nan, a_inf, b_inf, swap;
  logic        al_special;
  logic [31:0] al_special_val;
  logic [7:0]  shamt;
  logic [53:0] wide;
  logic [26:0] aligned;

  always_comb begin
    op_a  = unpack(a_q);
    op_b  = unpack(b_q);
    a_nan = (a_q[30:23] == EXP_MAX) && (a_q[22:0] != 23'd0);
    b_nan = (b_q[30:23] == EXP_MAX) && (b_q[22:0] != 23'd0);
    a_inf = (a_q[30:23] == EXP_MAX) && (a_q[22:0] == 23'd0);
    b_inf = (b_q[30:23] == EXP_MAX) && (b_q[22:0] == 23'd0);
    al_special     = a_nan | b_nan | a_inf | b_inf;
    al_special_val = QNAN;
    if (!(a_nan | b_nan | (a_inf & b_inf & (a_q[31] != b_q[31])))) begin
      al_special_val = a_inf ? a_q : b_q;
    end
    swap     = {op_b.exp, op_b.sig} > {op_a.exp, op_a.sig};
    op_big   = swap ? op_b : op_a;
    op_small = swap ? op_a : op_b;
    shamt    = op_big.exp - op_small.exp;
    wide     = {op_small.sig, 3'b000, 27'd0} >> shamt;
    if (shamt >= 8'd26) aligned = {26'd0, |op_small.sig};
    else                aligned = wide[53:27] | {26'd0, |wide[26:0]};
  end

  logic [4:0] lz;
  fpu_sp_lzc u_lzc (
    .din (sum_q[26:0]),
    .cnt (lz)
  );

  // ROUND: nearest-even on guard/round/sticky, then pack or saturate
  logic              round_up;
  logic [24:0]       rounded;
  logic signed [9:0] rnd_exp;
  logic [22:0]       rnd_frac;
  logic [31:0]       result_d;

  always_comb begin
    round_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rounded  = {1'b0, mant_q[26:3]} + {24'd0, round_up};
    rnd_exp  = exp_q + $signed({9'd0, rounded[24]});
    rnd_frac = rounded[24] ? rounded[23:1] : rounded[22:0];
    if (special_q)                        result_d = special_val_q;
    else if (zero_q)                      result_d = {sign_q & sign_s_q, 31'd0};
    else if (rnd_exp >= 10'sd255)         result_d = {sign_q, EXP_MAX, 23'd0};
    else if (rnd_exp <= 10'sd0)           result_d = {sign_q, 31'd0};
    else                                  result_d = {sign_q, rnd_exp[7:0], rnd_frac};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dval) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      sign_s_q      <= 1'b0;
      exp_q         <= '0;
      big_q         <= '0;
      small_q       <= '0;
      sum_q         <= '0;
      mant_q        <= '0;
      zero_q        <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      result_q      <= '0;
      rdy_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_q == S_ROUND);
      case (state_q)
        S_IDLE: if (dval) begin
          a_q <= din1;
          b_q <= din2;
        end
        S_ALIGN: begin
          sign_q        <= op_big.sign;
          sign_s_q      <= op_small.sign;
          exp_q         <= $signed({2'b00, op_big.exp});
          big_q         <= {op_big.sig, 3'b000};
          small_q       <= aligned;
          special_q     <= al_special;
          special_val_q <= al_special_val;
        end
        S_ADD: begin
          if (sign_q == sign_s_q) sum_q <= {1'b0, big_q} + {1'b0, small_q};
          else                    sum_q <= {1'b0, big_q} - {1'b0, small_q};
        end
        S_NORM: begin
          zero_q <= (sum_q == 28'd0);
          if (sum_q[27]) begin
            mant_q <= {sum_q[27:2], sum_q[1] | sum_q[0]};
            exp_q  <= exp_q + 10'sd1;
          end else begin
            mant_q <= sum_q[26:0] << lz;
            exp_q  <= exp_q - $signed({5'd0, lz});
          end
        end
        S_ROUND: result_q <= result_d;
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign rdy    = rdy_q;

endmodule

// File: tb/tb_fpu_sp_add.sv
// Scoreboard bench for fpu_sp_add: directed vectors queue expected sums,
// a monitor checks value, latency, single-cycle rdy and result hold.
module tb_fpu_sp_add;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din1, din2;
  logic        dval;
  logic [31:0] result;
  logic        rdy;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] held = 32'h0;

  fpu_sp_add dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .din1   (din1),
    .din2   (din2),
    .dval   (dval),
    .result (result),
    .rdy    (rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_result", result, 32'h0);
      check("reset_rdy", {31'd0, rdy}, 32'h0);
      held = 32'h0;
    end else if (rdy) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rdy: got result %h with no operation pending", result);
      end else begin
        e = sb.pop_front();
        check("result", result, e.val);
        check("latency", 32'(cyc - e.cyc), 32'd5);
        held = e.val;
      end
    end else begin
      check("result_hold", result, held);
    end
  end

  // Inputs are scrambled after capture to prove the operands are held.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    din1 = a;
    din2 = b;
    dval = 1'b1;
    @(posedge clk);
    sb.push_back('{val: e, cyc: cyc});
    @(negedge clk);
    dval = 1'b0;
    din1 = $urandom;
    din2 = $urandom;
    repeat (5) @(negedge clk);
  endtask

  task automatic back_to_back(input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e1,
                              input logic [31:0] a2, input logic [31:0] b2, input logic [31:0] e2);
    din1 = a1;
    din2 = b1;
    dval = 1'b1;
    @(posedge clk);
    sb.push_back('{val: e1, cyc: cyc});
    @(negedge clk);
    din1 = a2;
    din2 = b2;
    repeat (6) @(posedge clk);
    sb.push_back('{val: e2, cyc: cyc});
    @(negedge clk);
    dval = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic abort_in_norm(input logic [31:0] a, input logic [31:0] b);
    din1 = a;
    din2 = b;
    dval = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dval = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    din1  = 32'h0;
    din2  = 32'h0;
    dval  = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    issue(32'hC25ACCCD, 32'hC2786666, 32'hC2E9999A);  // -54.7 + -62.1
    issue(32'h3F800000, 32'h3F800000, 32'h40000000);
    issue(32'h3F800000, 32'hBF800000, 32'h00000000);  // exact cancel -> +0
    issue(32'h3F800000, 32'h33800000, 32'h3F800000);  // tie, even stays
    issue(32'h3F800001, 32'h33800000, 32'h3F800002);  // tie, odd rounds up
    issue(32'h40400000, 32'hC0000000, 32'h3F800000);  // 3 - 2
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);  // overflow
    issue(32'h7F800000, 32'hFF800000, 32'h7FC00000);  // +Inf + -Inf
    issue(32'h7F800001, 32'h3F800000, 32'h7FC00000);  // NaN in
    issue(32'hFF800000, 32'h3F800000, 32'hFF800000);  // -Inf + finite
    issue(32'h80000000, 32'h80000000, 32'h80000000);  // -0 + -0
    issue(32'h00000000, 32'h00000000, 32'h00000000);
    issue(32'h00400000, 32'h3F800000, 32'h3F800000);  // denormal as zero
    issue(32'h00800001, 32'h80800000, 32'h00000000);  // underflow flush

    back_to_back(32'h40000000, 32'h40000000, 32'h40800000,
                 32'h3F800000, 32'h40000000, 32'h40400000);

    abort_in_norm(32'h40A00000, 32'h40A00000);
    check("after_abort_result", result, 32'h0);
    issue(32'h3F800000, 32'h3F800000, 32'h40000000);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results still pending, expected 0", sb.size());
    end
    repeat (8) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
